// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU sequencer: state codes, mux selects,
// instruction field layout, condition codes and flag bit positions.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned FLAG_W  = 5;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned COND_W  = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEM_ADDR  = 4'd4,
        ST_MEM_READ  = 4'd5,
        ST_MEM_LATCH = 4'd6,
        ST_MEM_WRITE = 4'd7,
        ST_WRITEBACK = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_HALT      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BRANCH,
        CLS_HALT
    } instr_class_e;

    // Instruction word layout: opcode, Rdest/condition, extended opcode, low nibble
    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] ext;
        logic [3:0] lo;
    } instr_t;

    localparam logic [SEL_W-1:0] PC_SEL_INC  = 2'b00;
    localparam logic [SEL_W-1:0] PC_SEL_REL  = 2'b01;
    localparam logic [SEL_W-1:0] PC_SEL_REG  = 2'b10;

    localparam logic [SEL_W-1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [SEL_W-1:0] WB_SEL_MDR  = 2'b01;
    localparam logic [SEL_W-1:0] WB_SEL_LINK = 2'b10;

    localparam logic [DATA_W-1:0] HALT_INSTR = 16'hFFFF;
    localparam logic [DATA_W-1:0] NOP_INSTR  = 16'h0000;

    localparam logic [3:0] OPC_EXT   = 4'b0100;
    localparam logic [3:0] OPC_BCOND = 4'b1100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [COND_W-1:0] COND_EQ = 4'd0;
    localparam logic [COND_W-1:0] COND_NE = 4'd1;
    localparam logic [COND_W-1:0] COND_CS = 4'd2;
    localparam logic [COND_W-1:0] COND_CC = 4'd3;
    localparam logic [COND_W-1:0] COND_HI = 4'd4;
    localparam logic [COND_W-1:0] COND_LS = 4'd5;
    localparam logic [COND_W-1:0] COND_GT = 4'd6;
    localparam logic [COND_W-1:0] COND_LE = 4'd7;
    localparam logic [COND_W-1:0] COND_FS = 4'd8;
    localparam logic [COND_W-1:0] COND_FC = 4'd9;
    localparam logic [COND_W-1:0] COND_LO = 4'd10;
    localparam logic [COND_W-1:0] COND_HS = 4'd11;
    localparam logic [COND_W-1:0] COND_LT = 4'd12;
    localparam logic [COND_W-1:0] COND_GE = 4'd13;
    localparam logic [COND_W-1:0] COND_UC = 4'd14;
    localparam logic [COND_W-1:0] COND_NV = 4'd15;

    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    // Decide which path a freshly fetched word takes out of DECODE
    function automatic instr_class_e classify(input logic [DATA_W-1:0] instr);
        instr_t f;
        f = instr_t'(instr);
        if (instr == HALT_INSTR)
            return CLS_HALT;
        if (f.opcode == OPC_BCOND)
            return CLS_BRANCH;
        if (f.opcode == OPC_EXT) begin
            if (f.ext == EXT_LOAD || f.ext == EXT_STOR)
                return CLS_MEM;
            if (f.ext == EXT_JCOND || f.ext == EXT_JAL)
                return CLS_BRANCH;
        end
        return CLS_ALU;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and the CPU datapath.
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic                run;
    logic [DATA_W-1:0]   instr_in;
    logic [FLAG_W-1:0]   flags;
    logic [DATA_W-1:0]   ir;
    logic                ram_en_a;
    logic                ram_en_b;
    logic                ram_we_b;
    logic                mar_en;
    logic                mdr_en;
    logic                pc_en;
    logic [SEL_W-1:0]    pc_sel;
    logic                reg_we;
    logic [SEL_W-1:0]    wb_sel;
    logic                flag_en;
    logic                halted;
    logic [STATE_W-1:0]  state;

    modport master (
        input  run, instr_in, flags,
        output ir, ram_en_a, ram_en_b, ram_we_b, mar_en, mdr_en,
               pc_en, pc_sel, reg_we, wb_sel, flag_en, halted, state
    );

    modport slave (
        output run, instr_in, flags,
        input  ir, ram_en_a, ram_en_b, ram_we_b, mar_en, mdr_en,
               pc_en, pc_sel, reg_we, wb_sel, flag_en, halted, state
    );

endinterface

// File: rtl/cond_check.sv
// Branch condition evaluation from the {C,L,F,Z,N} flag register.
module cond_check
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              taken
);

    logic c, l, f, z, n;

    assign c = flags[FLAG_C];
    assign l = flags[FLAG_L];
    assign f = flags[FLAG_F];
    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_HI: taken = l;
            COND_LS: taken = ~l;
            COND_GT: taken = n;
            COND_LE: taken = ~n;
            COND_FS: taken = f;
            COND_FC: taken = ~f;
            COND_LO: taken = ~l & ~z;
            COND_HS: taken = l | z;
            COND_LT: taken = ~n & ~z;
            COND_GE: taken = n | z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: holds IR and steps each instruction through
// fetch/decode/execute/memory/writeback, decoding datapath controls from state and IR.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    instr_t            ir_fields;
    state_e            boundary;
    logic              taken;

    assign ir_fields = instr_t'(ir_q);
    assign boundary  = bus.run ? ST_FETCH : ST_IDLE;
    assign bus.ir    = ir_q;
    assign bus.state = STATE_W'(state_q);

    cond_check u_cond_check (
        .cond  (ir_fields.rd),
        .flags (bus.flags),
        .taken (taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control decode; every control defaults low
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        bus.ram_en_a = 1'b0;
        bus.ram_en_b = 1'b0;
        bus.ram_we_b = 1'b0;
        bus.mar_en   = 1'b0;
        bus.mdr_en   = 1'b0;
        bus.pc_en    = 1'b0;
        bus.pc_sel   = PC_SEL_INC;
        bus.reg_we   = 1'b0;
        bus.wb_sel   = WB_SEL_ALU;
        bus.flag_en  = 1'b0;
        bus.halted   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.ram_en_a = 1'b1;
                state_d      = ST_DECODE;
            end
            ST_DECODE: begin
                // RAM port A data arrives this cycle; capture it and classify
                ir_d = bus.instr_in;
                case (classify(bus.instr_in))
                    CLS_HALT:   state_d = ST_HALT;
                    CLS_MEM:    state_d = ST_MEM_ADDR;
                    CLS_BRANCH: state_d = ST_BRANCH;
                    default:    state_d = ST_EXECUTE;
                endcase
            end
            ST_EXECUTE: begin
                bus.pc_en  = 1'b1;
                bus.pc_sel = PC_SEL_INC;
                if (ir_fields != instr_t'(NOP_INSTR)) begin
                    bus.reg_we  = 1'b1;
                    bus.wb_sel  = WB_SEL_ALU;
                    bus.flag_en = 1'b1;
                end
                state_d = boundary;
            end
            ST_MEM_ADDR: begin
                bus.mar_en = 1'b1;
                state_d    = (ir_fields.ext == EXT_STOR) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                bus.ram_en_b = 1'b1;
                state_d      = ST_MEM_LATCH;
            end
            ST_MEM_LATCH: begin
                bus.mdr_en = 1'b1;
                state_d    = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                bus.reg_we = 1'b1;
                bus.wb_sel = WB_SEL_MDR;
                bus.pc_en  = 1'b1;
                bus.pc_sel = PC_SEL_INC;
                state_d    = boundary;
            end
            ST_MEM_WRITE: begin
                bus.ram_en_b = 1'b1;
                bus.ram_we_b = 1'b1;
                bus.pc_en    = 1'b1;
                bus.pc_sel   = PC_SEL_INC;
                state_d      = boundary;
            end
            ST_BRANCH: begin
                bus.pc_en = 1'b1;
                if (ir_fields.opcode == OPC_BCOND) begin
                    bus.pc_sel = taken ? PC_SEL_REL : PC_SEL_INC;
                end else if (ir_fields.ext == EXT_JAL) begin
                    bus.pc_sel = PC_SEL_REG;
                    bus.reg_we = 1'b1;
                    bus.wb_sel = WB_SEL_LINK;
                end else begin
                    bus.pc_sel = taken ? PC_SEL_REG : PC_SEL_INC;
                end
                state_d = boundary;
            end
            ST_HALT: begin
                bus.halted = 1'b1;
                state_d    = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Control vector: {ram_en_a, ram_en_b, ram_we_b, mar_en, mdr_en, pc_en, pc_sel[1:0], reg_we, wb_sel[1:0], flag_en, halted}
    logic [12:0] ctrl;
    assign ctrl = {bus.ram_en_a, bus.ram_en_b, bus.ram_we_b, bus.mar_en, bus.mdr_en,
                   bus.pc_en, bus.pc_sel, bus.reg_we, bus.wb_sel, bus.flag_en, bus.halted};

    localparam logic [12:0] M_RA    = 13'h1000;
    localparam logic [12:0] M_RB    = 13'h0800;
    localparam logic [12:0] M_WB    = 13'h0400;
    localparam logic [12:0] M_MAR   = 13'h0200;
    localparam logic [12:0] M_MDR   = 13'h0100;
    localparam logic [12:0] M_PC    = 13'h0080;
    localparam logic [12:0] PS_REG  = 13'h0040;
    localparam logic [12:0] PS_REL  = 13'h0020;
    localparam logic [12:0] M_RWE   = 13'h0010;
    localparam logic [12:0] WB_LINK = 13'h0008;
    localparam logic [12:0] WB_MDR  = 13'h0004;
    localparam logic [12:0] M_FLAG  = 13'h0002;
    localparam logic [12:0] M_HALT  = 13'h0001;

    function automatic bit ref_taken(input logic [3:0] cc, input logic [4:0] fl);
        bit c, l, f, z, n;
        c = fl[4]; l = fl[3]; f = fl[2]; z = fl[1]; n = fl[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return f;
            4'd9:  return !f;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        bus.run      = 1'b0;
        bus.instr_in = 16'h0000;
        bus.flags    = 5'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.ir, ctrl} !== {4'd0, 16'h0000, 13'h0}) begin
            errors++;
            $display("FAIL reset_init: state=%0d ir=%h ctrl=%h, want 0/0000/0000", bus.state, bus.ir, ctrl);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.instr_in = 16'h4304;
        bus.run = 1'b1;
        repeat (4) step();
        checks++;
        if ({bus.state, bus.ir, ctrl} !== {4'd5, 16'h4304, M_RB}) begin
            errors++;
            $display("FAIL reset_pre_memread: state=%0d ir=%h ctrl=%h, want 5/4304/%h", bus.state, bus.ir, ctrl, M_RB);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.ir, ctrl} !== {4'd0, 16'h0000, 13'h0}) begin
            errors++;
            $display("FAIL reset_async: state=%0d ir=%h ctrl=%h, want 0/0000/0000", bus.state, bus.ir, ctrl);
        end
        #1 reset = 1'b1;
        step();
        checks++;
        if ({bus.state, ctrl} !== {4'd1, M_RA}) begin
            errors++;
            $display("FAIL reset_release: state=%0d ctrl=%h, want 1/%h", bus.state, ctrl, M_RA);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  st[4] = '{4'd1, 4'd2, 4'd3, 4'd1};
        logic [12:0] ex[4] = '{M_RA, 13'h0, M_PC | M_RWE | M_FLAG, M_RA};
        do_reset();
        bus.instr_in = 16'h0105;
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.state, ctrl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL alu cyc%0d: state=%0d ctrl=%h, want %0d/%h", i + 1, bus.state, ctrl, st[i], ex[i]);
            end
        end
        checks++;
        if (bus.ir !== 16'h0105) begin
            errors++;
            $display("FAIL alu_ir: ir=%h, want 0105", bus.ir);
        end
    endtask

    task automatic test_nop();
        logic [3:0]  st[3] = '{4'd1, 4'd2, 4'd3};
        logic [12:0] ex[3] = '{M_RA, 13'h0, M_PC};
        do_reset();
        bus.instr_in = 16'h0000;
        bus.flags = 5'h1F;
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.state, ctrl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL nop cyc%0d: state=%0d ctrl=%h, want %0d/%h", i + 1, bus.state, ctrl, st[i], ex[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [3:0]  st[7] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd1};
        logic [12:0] ex[7] = '{M_RA, 13'h0, M_MAR, M_RB, M_MDR, M_RWE | WB_MDR | M_PC, M_RA};
        do_reset();
        bus.instr_in = 16'h4304;
        bus.run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if ({bus.state, ctrl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL load cyc%0d: state=%0d ctrl=%h, want %0d/%h", i + 1, bus.state, ctrl, st[i], ex[i]);
            end
        end
    endtask

    task automatic test_stor();
        logic [3:0]  st[5] = '{4'd1, 4'd2, 4'd4, 4'd7, 4'd1};
        logic [12:0] ex[5] = '{M_RA, 13'h0, M_MAR, M_RB | M_WB | M_PC, M_RA};
        do_reset();
        bus.instr_in = 16'h4344;
        bus.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus.state, ctrl} !== {st[i], ex[i]}) begin
                errors++;
                $display("FAIL stor cyc%0d: state=%0d ctrl=%h, want %0d/%h", i + 1, bus.state, ctrl, st[i], ex[i]);
            end
        end
    endtask

    task automatic test_bcond_eq();
        logic [4:0]  fl[2] = '{5'b00010, 5'b11101};
        logic [12:0] ex[2] = '{M_PC | PS_REL, M_PC};
        for (int k = 0; k < 2; k++) begin
            do_reset();
            bus.instr_in = 16'hC0F0;
            bus.flags = fl[k];
            bus.run = 1'b1;
            repeat (3) step();
            checks++;
            if ({bus.state, ctrl} !== {4'd9, ex[k]}) begin
                errors++;
                $display("FAIL bcond_eq flags=%b: state=%0d ctrl=%h, want 9/%h", fl[k], bus.state, ctrl, ex[k]);
            end
        end
    endtask

    task automatic test_jal();
        do_reset();
        bus.instr_in = 16'h4E85;
        bus.flags = 5'b0;
        bus.run = 1'b1;
        repeat (3) step();
        checks++;
        if ({bus.state, ctrl} !== {4'd9, M_PC | PS_REG | M_RWE | WB_LINK}) begin
            errors++;
            $display("FAIL jal: state=%0d ctrl=%h, want 9/%h", bus.state, ctrl, M_PC | PS_REG | M_RWE | WB_LINK);
        end
    endtask

    // Bcond (kind 0) and Jcond (kind 1) for every condition and flag value
    task automatic test_cond_sweep();
        logic [1:0] want;
        do_reset();
        bus.run = 1'b1;
        step();
        for (int kind = 0; kind < 2; kind++) begin
            for (int c = 0; c < 16; c++) begin
                for (int f = 0; f < 32; f++) begin
                    bus.instr_in = (kind == 0) ? {4'hC, 4'(c), 8'hF0} : {4'h4, 4'(c), 8'hC0};
                    bus.flags = 5'(f);
                    step();
                    step();
                    if (ref_taken(4'(c), 5'(f)))
                        want = (kind == 0) ? 2'b01 : 2'b10;
                    else
                        want = 2'b00;
                    checks++;
                    if (bus.state !== 4'd9 || bus.pc_sel !== want || bus.pc_en !== 1'b1) begin
                        errors++;
                        $display("FAIL cond_sweep kind=%0d cond=%0d flags=%b: state=%0d pc_en=%b pc_sel=%b, want 9/1/%b",
                                 kind, c, 5'(f), bus.state, bus.pc_en, bus.pc_sel, want);
                    end
                    step();
                end
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        bus.instr_in = 16'hFFFF;
        bus.run = 1'b1;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 5) bus.run = 1'b0;
            if (i == 10) bus.run = 1'b1;
            checks++;
            if ({bus.state, ctrl} !== {4'd10, M_HALT}) begin
                errors++;
                $display("FAIL halt cyc%0d: state=%0d ctrl=%h, want 10/%h", i, bus.state, ctrl, M_HALT);
            end
        end
    endtask

    task automatic test_stop();
        do_reset();
        bus.instr_in = 16'h0105;
        bus.run = 1'b1;
        repeat (3) step();
        checks++;
        if ({bus.state, ctrl} !== {4'd3, M_PC | M_RWE | M_FLAG}) begin
            errors++;
            $display("FAIL stop_exec: state=%0d ctrl=%h, want 3/%h", bus.state, ctrl, M_PC | M_RWE | M_FLAG);
        end
        bus.run = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus.state, bus.ir, ctrl} !== {4'd0, 16'h0105, 13'h0}) begin
            errors++;
            $display("FAIL stop_idle: state=%0d ir=%h ctrl=%h, want 0/0105/0000", bus.state, bus.ir, ctrl);
        end
        bus.run = 1'b1;
        step();
        checks++;
        if (bus.state !== 4'd1) begin
            errors++;
            $display("FAIL stop_restart: state=%0d, want 1", bus.state);
        end
    endtask

    // Consecutive instructions: FETCH-to-FETCH length and exactly one pc_en each
    task automatic test_back_to_back();
        logic [15:0] prog[6] = '{16'h0105, 16'h4304, 16'h4344, 16'hC0F0, 16'h4E85, 16'h0000};
        int          len[6]  = '{3, 6, 4, 3, 3, 3};
        int cyc, pcs;
        do_reset();
        bus.flags = 5'b00010;
        bus.run = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            bus.instr_in = prog[k];
            cyc = 0;
            pcs = 0;
            do begin
                step();
                cyc++;
                if (bus.pc_en === 1'b1) pcs++;
            end while (bus.state !== 4'd1 && cyc < 12);
            checks++;
            if (cyc !== len[k] || pcs !== 1) begin
                errors++;
                $display("FAIL b2b instr=%h: cycles=%0d pc_en_count=%0d, want %0d/1", prog[k], cyc, pcs, len[k]);
            end
        end
    endtask

    initial begin
        bus.run      = 1'b0;
        bus.instr_in = 16'h0000;
        bus.flags    = 5'b0;
        test_reset();
        test_alu();
        test_nop();
        test_load();
        test_stor();
        test_bcond_eq();
        test_jal();
        test_cond_sweep();
        test_halt();
        test_stop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
